hub75_scan_ctrl: RTL and testbench

- Scan controller for the HUB75 RGB LED matrix.
- Reads pixel pairs (top and bottom half-panel) from a double-buffered frame buffer and shifts one bit-plane per row pass.
- Drives blank, latch and row address, then holds the row lit for a binary-weighted time (binary code modulation), giving BITS-deep colour per channel.
- Performs frame-boundary buffer swaps on request from the frame-buffer writer.

---
 rtl/hub75_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED matrix scan controller: shifts one bit-plane per row pass
// from a double-buffered frame store and lights it for a BCM-weighted time.
module hub75_scan_ctrl #(
   parameter int COLS         = 32,
   parameter int ROW_ADDR_W   = 3,
   parameter int BITS         = 4,
   parameter int BASE_TICKS   = 8,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     swap_req,
   output logic                     swap_ack,
   output logic                     buf_sel,
   output logic                     rd_en,
   output logic [ROW_ADDR_W-1:0]    rd_row,
   output logic [$clog2(COLS)-1:0]  rd_col,
   input  logic [6*BITS-1:0]        rd_data,
   output logic                     r1,
   output logic                     g1,
   output logic                     b1,
   output logic                     r2,
   output logic                     g2,
   output logic                     b2,
   output logic [ROW_ADDR_W-1:0]    abc,
   output logic                     oclk,
   output logic                     lat,
   output logic                     oe,
   output logic                     frame_done
);

   localparam int COL_W = $clog2(COLS);
   localparam int PL_W  = (BITS > 1) ? $clog2(BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_BLANK,
      S_LATCH,
      S_DISP
   } state_t;

   state_t                state, state_d;
   logic [ROW_ADDR_W-1:0] row, row_d;
   logic [PL_W-1:0]       plane, plane_d;
   logic [COL_W-1:0]      col, col_d;
   logic [1:0]            ph, ph_d;
   logic [15:0]           cnt, cnt_d;
   logic [15:0]           ticks;
   logic [5:0]            rgb, rgb_d, pix;
   logic [BITS-1:0]       fld [6];

   logic                  oe_d, lat_d, oclk_d, rd_en_d;
   logic                  frame_done_d, swap_ack_d, buf_sel_d;
   logic [ROW_ADDR_W-1:0] rd_row_d, abc_d;
   logic [COL_W-1:0]      rd_col_d;

   assign {r1, g1, b1, r2, g2, b2} = rgb;
   assign ticks = 16'(BASE_TICKS) << plane;

   // Field 5 is r_top (MSBs of rd_data), field 0 is b_bot.
   always_comb begin
      for (int k = 0; k < 6; k++) begin
         fld[k] = rd_data[k*BITS +: BITS];
         pix[k] = fld[k][plane];
      end
   end

   always_comb begin
      state_d      = state;
      row_d        = row;
      plane_d      = plane;
      col_d        = col;
      ph_d         = ph;
      cnt_d        = cnt;
      rgb_d        = rgb;
      buf_sel_d    = buf_sel;
      frame_done_d = 1'b0;
      swap_ack_d   = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (en) begin
               state_d = S_SHIFT;
               row_d   = '0;
               plane_d = '0;
               col_d   = '0;
               ph_d    = '0;
            end
         end
         S_SHIFT: begin
            if (ph == 2'd1)
               rgb_d = pix;
            if (ph == 2'd2) begin
               ph_d = '0;
               if (col == COL_W'(COLS - 1)) begin
                  state_d = S_BLANK;
                  col_d   = '0;
                  cnt_d   = 16'(BLANK_CYCLES - 1);
               end else begin
                  col_d = col + COL_W'(1);
               end
            end else begin
               ph_d = ph + 2'd1;
            end
         end
         S_BLANK: begin
            if (cnt == '0)
               state_d = S_LATCH;
            else
               cnt_d = cnt - 16'd1;
         end
         S_LATCH: begin
            state_d = S_DISP;
            cnt_d   = ticks - 16'd1;
         end
         S_DISP: begin
            if (cnt != '0) begin
               cnt_d = cnt - 16'd1;
            end else if (plane != PL_W'(BITS - 1)) begin
               plane_d = plane + PL_W'(1);
               state_d = S_SHIFT;
            end else if (row != {ROW_ADDR_W{1'b1}}) begin
               plane_d = '0;
               row_d   = row + ROW_ADDR_W'(1);
               state_d = S_SHIFT;
            end else begin
               // Frame end: the only point where a buffer swap may land.
               plane_d      = '0;
               row_d        = '0;
               frame_done_d = 1'b1;
               if (swap_req) begin
                  buf_sel_d  = ~buf_sel;
                  swap_ack_d = 1'b1;
               end
               state_d = en ? S_SHIFT : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      oe_d     = (state_d != S_DISP);
      lat_d    = (state_d == S_LATCH);
      oclk_d   = (state_d == S_SHIFT) && (ph_d == 2'd2);
      rd_en_d  = (state_d == S_SHIFT) && (ph_d == 2'd0);
      rd_row_d = rd_en_d ? row_d : rd_row;
      rd_col_d = rd_en_d ? col_d : rd_col;
      abc_d    = lat_d ? row_d : abc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         row        <= '0;
         plane      <= '0;
         col        <= '0;
         ph         <= '0;
         cnt        <= '0;
         rgb        <= '0;
         oe         <= 1'b1;
         lat        <= 1'b0;
         oclk       <= 1'b0;
         rd_en      <= 1'b0;
         rd_row     <= '0;
         rd_col     <= '0;
         abc        <= '0;
         buf_sel    <= 1'b0;
         swap_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         row        <= row_d;
         plane      <= plane_d;
         col        <= col_d;
         ph         <= ph_d;
         cnt        <= cnt_d;
         rgb        <= rgb_d;
         oe         <= oe_d;
         lat        <= lat_d;
         oclk       <= oclk_d;
         rd_en      <= rd_en_d;
         rd_row     <= rd_row_d;
         rd_col     <= rd_col_d;
         abc        <= abc_d;
         buf_sel    <= buf_sel_d;
         swap_ack   <= swap_ack_d;
         frame_done <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: frame-level reference model feeds an event
// scoreboard; a negedge monitor pops and compares panel events.
module tb_hub75_scan_ctrl;

   localparam int COLS  = 4;
   localparam int RW    = 1;
   localparam int BITS  = 2;
   localparam int BASE  = 2;
   localparam int BLANK = 2;
   localparam int NROW  = 1 << RW;
   localparam int CW    = $clog2(COLS);

   localparam int K_OCLK = 0;
   localparam int K_LAT  = 1;
   localparam int K_OE   = 2;
   localparam int K_FD   = 3;

   typedef struct {
      int kind;
      int val;
      int aux;
   } ev_t;

   logic            clk, reset, en, swap_req;
   logic            swap_ack, buf_sel, rd_en;
   logic [RW-1:0]   rd_row, abc;
   logic [CW-1:0]   rd_col;
   logic [6*BITS-1:0] rd_data;
   logic            r1, g1, b1, r2, g2, b2;
   logic            oclk, lat, oe, frame_done;

   logic [6*BITS-1:0] mem [2][NROW][COLS];

   ev_t q[$];
   int  checks, errors;
   int  exp_buf;
   int  cyc, start, rd_cyc, last_lat, oe_cnt;
   bit  need_start, prev_rd_en, prev_oclk, prev_buf;

   hub75_scan_ctrl #(
      .COLS(COLS), .ROW_ADDR_W(RW), .BITS(BITS),
      .BASE_TICKS(BASE), .BLANK_CYCLES(BLANK)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .swap_req(swap_req),
      .swap_ack(swap_ack), .buf_sel(buf_sel), .rd_en(rd_en),
      .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
      .abc(abc), .oclk(oclk), .lat(lat), .oe(oe),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame store: data appears the cycle after the read strobe.
   always @(posedge clk)
      if (rd_en) rd_data <= mem[buf_sel][rd_row][rd_col];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic finish_tb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   task automatic get_ev(input int kind, output ev_t e, output bit ok);
      ok = 1'b0;
      e = '{kind: -1, val: 0, aux: 0};
      if (q.size() == 0) begin
         chk("event_underflow", kind, -1);
      end else begin
         e = q.pop_front();
         chk("event_kind", kind, e.kind);
         ok = (e.kind == kind);
      end
   endtask

   function automatic int plane_bits(input logic [6*BITS-1:0] v, input int p);
      int r = 0;
      for (int k = 5; k >= 0; k--)
         r = (r << 1) | int'((v >> (k*BITS + p)) & 1);
      return r;
   endfunction

   // Reference: one frame = every row, every plane, in order.
   task automatic push_frame(input bit swap);
      int tot = 0;
      int prev = -1;
      for (int r = 0; r < NROW; r++)
         for (int p = 0; p < BITS; p++) begin
            for (int c = 0; c < COLS; c++)
               q.push_back('{K_OCLK, plane_bits(mem[exp_buf][r][c], p), 0});
            q.push_back('{K_LAT, r,
               (prev < 0) ? -1 : 3*COLS + BLANK + 1 + (BASE << prev)});
            q.push_back('{K_OE, BASE << p, 0});
            tot += 3*COLS + BLANK + 1 + (BASE << p);
            prev = p;
         end
      if (swap) exp_buf ^= 1;
      q.push_back('{K_FD, (int'(swap) << 1) | exp_buf, tot});
   endtask

   task automatic reset_monitor();
      need_start = 1'b1;
      prev_rd_en = 1'b0;
      prev_oclk  = 1'b0;
      prev_buf   = 1'b0;
      oe_cnt     = 0;
      last_lat   = -1;
      rd_cyc     = -100;
   endtask

   always @(negedge clk) begin
      ev_t e;
      bit ok;
      if (reset) begin
         cyc++;
         if (!oe) begin
            oe_cnt++;
         end else if (oe_cnt > 0) begin
            get_ev(K_OE, e, ok);
            if (ok) chk("oe_low_len", oe_cnt, e.val);
            oe_cnt = 0;
         end
         if (frame_done) begin
            get_ev(K_FD, e, ok);
            if (ok) begin
               chk("swap_ack", int'(swap_ack), (e.val >> 1) & 1);
               chk("buf_sel", int'(buf_sel), e.val & 1);
               chk("frame_len", cyc - start, e.aux);
            end
            need_start = 1'b1;
         end else begin
            chk("buf_sel_stable", int'(buf_sel), int'(prev_buf));
            chk("swap_ack_idle", int'(swap_ack), 0);
         end
         if (rd_en) begin
            chk("rd_en_gap", int'(prev_rd_en), 0);
            if (need_start) begin
               start = cyc;
               need_start = 1'b0;
            end
            rd_cyc = cyc;
         end
         if (oclk) begin
            chk("oclk_width", int'(prev_oclk), 0);
            chk("rd_to_oclk", cyc - rd_cyc, 2);
            chk("oe_in_shift", int'(oe), 1);
            get_ev(K_OCLK, e, ok);
            if (ok) chk("colour", int'({r1, g1, b1, r2, g2, b2}), e.val);
         end
         if (lat) begin
            chk("oe_at_lat", int'(oe), 1);
            get_ev(K_LAT, e, ok);
            if (ok) begin
               chk("abc", int'(abc), e.val);
               if (e.aux >= 0) chk("lat_period", cyc - last_lat, e.aux);
            end
            last_lat = cyc;
         end
         prev_rd_en = rd_en;
         prev_oclk  = oclk;
         prev_buf   = buf_sel;
      end
   end

   task automatic wait_rd_en();
      int n = 0;
      while (!rd_en) begin
         @(negedge clk);
         if (++n > 50) begin
            chk("timeout_rd_en", 0, 1);
            finish_tb();
         end
      end
   endtask

   task automatic wait_fd();
      int n = 0;
      do begin
         @(negedge clk);
         if (++n > 200) begin
            chk("timeout_frame_done", 0, 1);
            finish_tb();
         end
      end while (!frame_done);
   endtask

   task automatic idle_check(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_oe", int'(oe), 1);
         chk("idle_act", int'({lat, oclk, rd_en, frame_done}), 0);
      end
   endtask

   // plan: 0 no swap, 1 swap_req mid-frame, 2 swap_req in the last cycle
   task automatic run_frame(input int plan, input bit drop);
      int flen = NROW * (BITS * (3*COLS + BLANK + 1)
                 + BASE * ((1 << BITS) - 1));
      int mid = $urandom_range(5, flen - 12);
      push_frame(plan != 0);
      wait_rd_en();
      for (int t = 1; t < flen; t++) begin
         @(negedge clk);
         if (plan == 1 && t == mid) swap_req = 1'b1;
         if (plan == 2 && t == flen - 1) swap_req = 1'b1;
         if (drop && t == 10) en = 1'b0;
      end
      wait_fd();
      swap_req = 1'b0;
   endtask

   task automatic reset_test();
      int n = 0;
      push_frame(1'b0);
      wait_rd_en();
      while (oe) begin
         @(negedge clk);
         if (++n > 100) begin
            chk("timeout_display", 0, 1);
            finish_tb();
         end
      end
      #1 reset = 1'b0;
      #1;
      chk("async_rst_oe", int'(oe), 1);
      chk("async_rst_zero", int'({lat, oclk, rd_en, frame_done, swap_ack,
          buf_sel, r1, g1, b1, r2, g2, b2, abc, rd_row, rd_col}), 0);
      q.delete();
      exp_buf = 0;
      reset_monitor();
      repeat (3) @(negedge clk);
      chk("rst_hold_oe", int'(oe), 1);
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_buf = 0;
      cyc = 0;
      start = 0;
      reset_monitor();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < NROW; r++)
            for (int c = 0; c < COLS; c++)
               mem[b][r][c] = (6*BITS)'($urandom);
      reset = 1'b0;
      en = 1'b0;
      swap_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_oe", int'(oe), 1);
      chk("reset_zero", int'({lat, oclk, rd_en, frame_done, swap_ack,
          buf_sel, abc, rd_row, rd_col}), 0);
      reset = 1'b1;
      idle_check(20);
      chk("idle_buf_sel", int'(buf_sel), 0);
      chk("idle_abc", int'(abc), 0);

      en = 1'b1;
      run_frame(0, 1'b0);
      run_frame(1, 1'b0);
      run_frame(2, 1'b0);
      run_frame(int'($urandom_range(0, 2)), 1'b1);
      idle_check(20);
      en = 1'b1;
      run_frame(int'($urandom_range(0, 2)), 1'b0);
      run_frame(2, 1'b0);
      reset_test();
      run_frame(1, 1'b0);
      run_frame(0, 1'b1);
      idle_check(10);
      chk("queue_empty", q.size(), 0);
      finish_tb();
   end

endmodule
